// File: rtl/digit_scan_ctrl.sv
// ---------------------------------------------------------------------------
// digit_scan_ctrl
//
// Multiplexed seven-segment display scan controller. It runs from the system
// clock and steps a one-hot common-anode enable across DIGITS positions. Each
// position is held for DWELL clock cycles before the scan moves on. It also
// exports the index of the active digit, which drives the segment-data mux.
//
// Extra behaviour on top of a plain ring scanner:
//   - blank_mask forces individual anodes off. A blanked digit still takes its
//     full dwell slot, so the frame period is always DIGITS*DWELL cycles.
//   - enable freezes the scan position.
//   - frame_tick pulses for one cycle each time the index wraps to 0.
//
// Optional feature, selected by the compile-time macro SCAN_GHOST_GUARD_EN:
//   When the macro is defined, every anode is off during the first cycle
//   (cnt == 0) of each digit slot. This dead time stops ghosting. digit_sel
//   changes at the start of that gap, so the segment data has settled before
//   the new anode turns on. The gap needs DWELL >= 2.
//
// Parameters:
//   DIGITS     : number of digit positions, 2..16
//   DWELL      : cycles per digit, 1..65536 (>= 2 with SCAN_GHOST_GUARD_EN)
//   ACTIVE_LOW : 1 = anode active at 0, 0 = anode active at 1
//   SELW       : derived width of digit_sel; leave at its default
//
// Ports:
//   clock      in   1       system clock, all state updates on rising edge
//   reset      in   1       synchronous active-high reset
//   enable     in   1       scan advance enable; low freezes cnt and idx
//   blank_mask in   DIGITS  bit i = 1 forces anode i inactive
//   anode      out  DIGITS  registered anode drive, at most one bit active
//   digit_sel  out  SELW    registered index of the current digit
//   frame_tick out  1       registered one-cycle pulse when the index wraps
// ---------------------------------------------------------------------------
module digit_scan_ctrl #(
    parameter int DIGITS     = 4,
    parameter int DWELL      = 4,
    parameter bit ACTIVE_LOW = 1'b1,
    parameter int SELW       = $clog2(DIGITS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [DIGITS-1:0] blank_mask,
    output logic [DIGITS-1:0] anode,
    output logic [SELW-1:0]   digit_sel,
    output logic              frame_tick
);

    // A one-bit counter is kept when DWELL = 1. Its maximum value is 0, so
    // every enabled cycle is a dwell boundary.
    localparam int CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(DWELL - 1);
    localparam logic [SELW-1:0] IDX_MAX = SELW'(DIGITS - 1);

`ifdef SCAN_GHOST_GUARD_EN
    localparam bit GHOST_GUARD = 1'b1;
`else
    localparam bit GHOST_GUARD = 1'b0;
`endif

    // Reject illegal configurations at elaboration time.
    if (DIGITS < 2 || DIGITS > 16) begin : g_bad_digits
        $fatal(1, "digit_scan_ctrl: DIGITS must be in 2..16");
    end
    if (DWELL < 1 || DWELL > 65536) begin : g_bad_dwell
        $fatal(1, "digit_scan_ctrl: DWELL must be in 1..65536");
    end
    if (GHOST_GUARD && DWELL < 2) begin : g_bad_guard
        $fatal(1, "digit_scan_ctrl: ghost guard requires DWELL >= 2");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [SELW-1:0]   idx_q, idx_d;
    logic              tick_d;
    logic [DIGITS-1:0] anode_q, anode_d;

    // Anode pattern for a given position: the active digit is idx, unless
    // that digit is blanked or the ghost-guard gap is open (cnt == 0).
    // The polarity is applied last, so the inactive level is the same for
    // every bit.
    function automatic logic [DIGITS-1:0] decode_anode(
        input logic [SELW-1:0]   idx,
        input logic [CNTW-1:0]   cnt,
        input logic [DIGITS-1:0] mask
    );
        logic [DIGITS-1:0] act;
        act = '0;
        for (int k = 0; k < DIGITS; k++) begin
            act[k] = (idx == SELW'(k)) && !mask[k];
        end
        if (GHOST_GUARD && cnt == '0) begin
            act = '0;
        end
        return ACTIVE_LOW ? ~act : act;
    endfunction

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default before any
        // branch. A path that left one unassigned would infer a latch.
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        tick_d = 1'b0;

        if (enable) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNTW'(1);
            end else begin
                cnt_d = '0;
                // Wrap by explicit compare-and-clear. With a DIGITS that
                // is not a power of 2, idx never reaches the unused codes.
                if (idx_q == IDX_MAX) begin
                    idx_d  = '0;
                    tick_d = 1'b1;
                end else begin
                    idx_d = idx_q + SELW'(1);
                end
            end
        end

        // The anode register is loaded from the next-state values. This
        // keeps anode, digit_sel and frame_tick aligned on the same edge.
        // While enable is low, the anode still follows blank_mask.
        anode_d = decode_anode(idx_d, cnt_d, blank_mask);
    end

    // ------------------------------------------------------------------
    // Registers (synchronous reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments only. All
        // registers then sample the values from before the edge.
        if (reset) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            frame_tick <= 1'b0;
            // The reset anode value still depends on blank_mask[0], and on
            // the ghost gap when the guard is compiled in.
            anode_q    <= decode_anode('0, '0, blank_mask);
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            frame_tick <= tick_d;
            anode_q    <= anode_d;
        end
    end

    assign anode     = anode_q;
    assign digit_sel = idx_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_digit_scan_ctrl
//
// Self-checking bench for digit_scan_ctrl. It drives two instances:
//   u4 : DIGITS=4, DWELL=3, ACTIVE_LOW=1
//   u3 : DIGITS=3, DWELL=1 (2 with the ghost guard), ACTIVE_LOW=0
//
// The expected values come from an arithmetic model. It counts the enabled
// clock edges since reset (n). Each digit position then follows directly:
//   idx = (n / DWELL) % DIGITS
//   cnt = n % DWELL
// frame_tick is expected on an enabled edge where n % (DIGITS*DWELL) == 0.
// ---------------------------------------------------------------------------
module tb_digit_scan_ctrl;

`ifdef SCAN_GHOST_GUARD_EN
    localparam bit GHOST    = 1'b1;
    localparam int D3_DWELL = 2;
`else
    localparam bit GHOST    = 1'b0;
    localparam int D3_DWELL = 1;
`endif

    localparam int D4_DIGITS = 4;
    localparam int D4_DWELL  = 3;
    localparam int D3_DIGITS = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [3:0] blank4 = '0;
    logic [2:0] blank3 = '0;

    logic [3:0] anode4;
    logic [1:0] sel4;
    logic       tick4;
    logic [2:0] anode3;
    logic [1:0] sel3;
    logic       tick3;

    int checks   = 0;
    int failures = 0;

    // Model state: enabled edges since reset and the expected tick.
    int  n4 = 0;
    int  n3 = 0;
    bit  etick4 = 1'b0;
    bit  etick3 = 1'b0;
    logic [3:0] bm4_at_edge = '0;
    logic [2:0] bm3_at_edge = '0;

    digit_scan_ctrl #(.DIGITS(D4_DIGITS), .DWELL(D4_DWELL), .ACTIVE_LOW(1'b1)) u4 (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .blank_mask (blank4),
        .anode      (anode4),
        .digit_sel  (sel4),
        .frame_tick (tick4)
    );

    digit_scan_ctrl #(.DIGITS(D3_DIGITS), .DWELL(D3_DWELL), .ACTIVE_LOW(1'b0)) u3 (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .blank_mask (blank3),
        .anode      (anode3),
        .digit_sel  (sel3),
        .frame_tick (tick3)
    );

    always #5 clock = ~clock;

    // Watchdog: the bench must end on its own.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Expected anode vector, computed from the model counters. Bits above
    // DIGITS are zero.
    function automatic logic [15:0] exp_anode(input int n, input int digits,
                                              input int dwell, input logic [15:0] bm,
                                              input bit active_low);
        logic [15:0] v;
        int idx;
        int cnt;
        idx = (n / dwell) % digits;
        cnt = n % dwell;
        v = '0;
        if (!bm[idx] && !(GHOST && cnt == 0)) v[idx] = 1'b1;
        if (active_low) v = ~v;
        return v & 16'((32'd1 << digits) - 1);
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".anode4"}, 16'(anode4),
              exp_anode(n4, D4_DIGITS, D4_DWELL, 16'(bm4_at_edge), 1'b1));
        check({tag, ".sel4"},   16'(sel4),  16'((n4 / D4_DWELL) % D4_DIGITS));
        check({tag, ".tick4"},  16'(tick4), 16'(etick4));
        check({tag, ".anode3"}, 16'(anode3),
              exp_anode(n3, D3_DIGITS, D3_DWELL, 16'(bm3_at_edge), 1'b0));
        check({tag, ".sel3"},   16'(sel3),  16'((n3 / D3_DWELL) % D3_DIGITS));
        check({tag, ".tick3"},  16'(tick3), 16'(etick3));
    endtask

    // Apply the inputs for one clock and advance the model, then check
    // the outputs 1 time unit after the edge.
    task automatic step(input string tag, input bit rst, input bit en,
                        input logic [3:0] bm4, input logic [2:0] bm3);
        reset  = rst;
        enable = en;
        blank4 = bm4;
        blank3 = bm3;
        @(posedge clock);
        bm4_at_edge = bm4;
        bm3_at_edge = bm3;
        if (rst) begin
            n4 = 0; n3 = 0; etick4 = 1'b0; etick3 = 1'b0;
        end else if (en) begin
            n4++; n3++;
            etick4 = (n4 % (D4_DIGITS * D4_DWELL)) == 0;
            etick3 = (n3 % (D3_DIGITS * D3_DWELL)) == 0;
        end else begin
            etick4 = 1'b0; etick3 = 1'b0;
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        bit found;
        @(negedge clock);

        // Reset with digit 0 blanked: all anodes inactive.
        step("rst_blank0", 1'b1, 1'b1, 4'b0001, 3'b001);
        // Reset wins over enable; digit 0 active.
        step("rst", 1'b1, 1'b1, 4'b0000, 3'b000);

        // Reset scan: 1110 x3, 1101, 1011, 0111, 1110 with tick at cycle 12.
        for (int i = 0; i < 14; i++) step("scan", 1'b0, 1'b1, 4'b0000, 3'b000);
        // Directed spot check after 14 enabled edges: idx = 4 % 4 = 0, cnt = 2.
        check("scan.anode_direct", 16'(anode4), 16'h000E);

        // Blanking of digit 2 over more than a full frame.
        for (int i = 0; i < 14; i++) step("blank", 1'b0, 1'b1, 4'b0100, 3'b010);

        // Enable hold at cnt=1, idx=2.
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            if (n4 % 12 == 7) found = 1'b1;
            else step("seek_hold", 1'b0, 1'b1, 4'b0000, 3'b000);
        end
        check("seek_hold.found", 16'(found), 16'd1);
        for (int i = 0; i < 5; i++) step("hold", 1'b0, 1'b0, 4'b0000, 3'b000);
        check("hold.sel_direct", 16'(sel4), 16'd2);
        // The blank mask is still tracked while the scan is frozen.
        step("hold_blank", 1'b0, 1'b0, 4'b0100, 3'b000);
        for (int i = 0; i < 4; i++) step("resume", 1'b0, 1'b1, 4'b0000, 3'b000);

        // Reset mid-scan at idx=3.
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            if ((n4 / D4_DWELL) % D4_DIGITS == 3) found = 1'b1;
            else step("seek_rst", 1'b0, 1'b1, 4'b0000, 3'b000);
        end
        check("seek_rst.found", 16'(found), 16'd1);
        step("mid_rst", 1'b1, 1'b1, 4'b0000, 3'b000);
        check("mid_rst.tick_direct", 16'(tick4), 16'd0);

        // Randomized phase.
        for (int i = 0; i < 400; i++) begin
            logic [3:0] m4;
            logic [2:0] m3;
            m4 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            m3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
            step("rand", $urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, m4, m3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
